// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: sync byte and state encodings.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Little-endian assembly of the 16-bit word count.
    function automatic logic [15:0] word_count(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer and mid-bit sampling.
//
// state    | meaning
// ---------+-----------------------------------------------
// RX_IDLE  | line idle, watching for a falling edge
// RX_START | waiting to half-bit, confirm start still low
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling stop bit; high -> byte, low -> error
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;

    // Bit timing: the down-counter reaching zero marks each mid-bit sample point.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        state_d   = RX_DATA;
                        cnt_d     = FULL_M1;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchronizer, edge history and receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image and writes it into instruction RAM.
// Define BOOT_CSUM_EN to compare the trailing checksum byte against the 8-bit
// sum of all length and data bytes; otherwise the checksum byte is only consumed.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_SYNC | discard bytes until 0xA5
// ST_LEN0 | capture word count low byte
// ST_LEN1 | capture high byte, range-check the count
// ST_DATA | assemble 4-byte words, write each to RAM
// ST_CSUM | consume (and optionally check) checksum byte
// ST_DONE | image accepted, core released (terminal)
// ST_ERR  | framing/length/checksum error (terminal)
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [16:0] MAX_WORDS    = 17'd1 << ADDR_W;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    boot_state_t       state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [15:0]       n_words;
    logic              csum_ok;
`ifdef BOOT_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Frame parser: advances on each received byte, remaining-word counter
    // terminates the data phase at zero.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_we_q ? ram_addr_q + 1'b1 : ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        n_words     = word_count(len_lo_q, byte_data);
`ifdef BOOT_CSUM_EN
        csum_d  = csum_q;
        csum_ok = (byte_data == csum_q);
        if (byte_valid && (state_q inside {ST_LEN0, ST_LEN1, ST_DATA})) begin
            csum_d = csum_q + byte_data;
        end
`else
        csum_ok = 1'b1;
`endif
        if (frame_err && state_q != ST_DONE && state_q != ST_ERR) begin
            state_d = ST_ERR;
        end else if (byte_valid) begin
            case (state_q)
                ST_SYNC: if (byte_data == SYNC_BYTE) state_d = ST_LEN0;
                ST_LEN0: begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN1;
                end
                ST_LEN1: begin
                    if (n_words == 16'd0) begin
                        state_d = ST_CSUM;
                    end else if ({1'b0, n_words} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        word_cnt_d = n_words;
                        byte_idx_d = 2'd0;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    word_d     = {byte_data, word_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        ram_wdata_d = {byte_data, word_q[31:8]};
                        ram_we_d    = 1'b1;
                        word_cnt_d  = word_cnt_q - 16'd1;
                        if (word_cnt_q == 16'd1) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: state_d = csum_ok ? ST_DONE : ST_ERR;
                default: ;
            endcase
        end
    end

    // Parser and RAM-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            len_lo_q    <= 8'h00;
            word_cnt_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'h0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
`ifdef BOOT_CSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
`ifdef BOOT_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign core_rst  = (state_q != ST_DONE);
    assign boot_done = (state_q == ST_DONE);
    assign boot_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader; a second instance with ADDR_W=2 shares
// the serial line to exercise the length range check.
module tb_uart_boot_loader;

    localparam int CLK_FREQ = 1843200;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;

`ifdef BOOT_CSUM_EN
    localparam logic [7:0] GOOD_CSUM  = 8'hB8;
    localparam logic [7:0] EMPTY_CSUM = 8'h00;
    localparam logic       BAD_IS_ERR = 1'b1;
`else
    localparam logic [7:0] GOOD_CSUM  = 8'hB9;
    localparam logic [7:0] EMPTY_CSUM = 8'h02;
    localparam logic       BAD_IS_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        ram_we, core_rst, boot_done, boot_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we2, core_rst2, boot_done2, boot_err2;
    logic [1:0]  ram_addr2;
    logic [31:0] ram_wdata2;

    uart_boot_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    uart_boot_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .core_rst(core_rst2), .boot_done(boot_done2), .boot_err(boot_err2)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_n = 0;
    int          wr2_n = 0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          last_bv_cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log and DONE-latency monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we) begin
            if (wr_n < 8) begin
                wr_addr[wr_n] = 32'(ram_addr);
                wr_data[wr_n] = ram_wdata;
            end
            wr_n = wr_n + 1;
        end
        if (ram_we2) wr2_n = wr2_n + 1;
        if (dut.byte_valid) last_bv_cyc = cyc;
        if (boot_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        uart_rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_bit();
        end
        uart_rx = stop;
        wait_bit();
        uart_rx = 1'b1;
        wait_bit();
        wait_bit();
    endtask

    task automatic send_frame(input logic [7:0] csum);
        logic [7:0] body [11];
        body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 11; i++) send_byte(body[i], 1'b1);
        send_byte(csum, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_n = 0;
        wr2_n = 0;
        done_seen = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_boot_err", 32'(boot_err), 32'd0);

        // Good two-word image
        send_frame(GOOD_CSUM);
        @(negedge clk);
        check("good_wr_count", 32'(wr_n), 32'd2);
        check("good_addr0", wr_addr[0], 32'd0);
        check("good_data0", wr_data[0], 32'h00000013);
        check("good_addr1", wr_addr[1], 32'd1);
        check("good_data1", wr_data[1], 32'h00100093);
        check("good_boot_done", 32'(boot_done), 32'd1);
        check("good_core_rst", 32'(core_rst), 32'd0);
        check("good_boot_err", 32'(boot_err), 32'd0);
        check("good_done_latency", 32'(done_cyc - last_bv_cyc), 32'd1);

        // Bytes after DONE are ignored
        send_frame(GOOD_CSUM);
        @(negedge clk);
        check("ignore_wr_count", 32'(wr_n), 32'd2);
        check("ignore_boot_done", 32'(boot_done), 32'd1);

        // Wrong checksum byte
        do_reset();
        send_frame(8'h00);
        @(negedge clk);
        check("csum_wr_count", 32'(wr_n), 32'd2);
        check("csum_boot_err", 32'(boot_err), 32'(BAD_IS_ERR));
        check("csum_boot_done", 32'(boot_done), 32'(!BAD_IS_ERR));
        check("csum_core_rst", 32'(core_rst), 32'(BAD_IS_ERR));

        // Leading junk, zero-length image
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(EMPTY_CSUM, 1'b1);
        @(negedge clk);
        check("empty_wr_count", 32'(wr_n), 32'd0);
        check("empty_boot_done", 32'(boot_done), 32'd1);

        // Framing error on 6th byte
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("frame_boot_err", 32'(boot_err), 32'd1);
        check("frame_wr_count", 32'(wr_n), 32'd0);
        check("frame_boot_done", 32'(boot_done), 32'd0);

        // Abort mid-frame with reset, then reload
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        do_reset();
        @(negedge clk);
        check("abort_addr_cleared", 32'(ram_addr), 32'd0);
        send_frame(GOOD_CSUM);
        @(negedge clk);
        check("abort_wr_count", 32'(wr_n), 32'd2);
        check("abort_addr0", wr_addr[0], 32'd0);
        check("abort_addr1", wr_addr[1], 32'd1);
        check("abort_data1", wr_data[1], 32'h00100093);
        check("abort_boot_done", 32'(boot_done), 32'd1);

        // Length 5 against a 4-word RAM (dut2); dut keeps waiting for data
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        check("len_boot_err", 32'(boot_err2), 32'd1);
        check("len_core_rst", 32'(core_rst2), 32'd1);
        check("len_wr_count", 32'(wr2_n), 32'd0);
        check("len_wide_no_err", 32'(boot_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
